dmem_access_unit: RTL
=====================

# dmem_access_unit

Data-memory access unit for the 5-stage RV32I pipeline: the responder side of the Memory-stage controls (`mem_rw`, load/store qualification, `funct3`) produced by pipeline control. It turns the XM-stage access into a request/grant transaction on the data-memory bus and computes byte enables and store-lane replication. It stalls the pipeline until the access completes and delivers an aligned, sign- or zero-extended load value to the MW stage.

## Interface
Parameters:
- DATAW, 32, data width; only 32 is supported.
- BUS_ADDRW, 32, byte-address width on the bus.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state and registered outputs immediately.
- access_valid  in  1  XM instruction is a load or a store; held stable while `stall` is high.
- mem_rw  in  1  1 = store, 0 = load.
- funct3_xm  in  3  access size and signedness.
- addr_xm  in  BUS_ADDRW  ALU-computed byte address.
- store_data_xm  in  DATAW  rs2 value, already bypassed.
- bus_req  out  1  request; registered.
- bus_we  out  1  write enable; registered.
- bus_addr  out  BUS_ADDRW  word-aligned address, low 2 bits forced 0; registered.
- bus_be  out  4  byte enables; registered.
- bus_wdata  out  DATAW  lane-replicated store data; registered.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read data valid this cycle.
- bus_rdata  in  DATAW  read word.
- stall  out  1  freeze PC, DX, and XM registers.
- load_data_mw  out  DATAW  extended load result for writeback; registered.
- misalign  out  1  misaligned access flagged; registered, 1-cycle pulse.

## Operation
- FSM states:
  - IDLE: stall = access_valid. On access_valid, latch addr, size, and data, set up the bus outputs, and go to REQ. If the macro is enabled and the access is misaligned, go to DONE instead.
  - REQ: bus_req = 1 with bus_we, bus_addr, bus_be, and bus_wdata held stable. When bus_gnt is seen, drop bus_req on the next edge. A store goes to DONE; a load goes to RESP.
  - RESP: wait for bus_rvalid. On bus_rvalid, capture the extended data into load_data_mw and go to DONE. bus_rvalid arriving in the same cycle as bus_gnt is not legal.
  - DONE: stall = 0 so the pipeline advances; no new access is accepted here. Always go to IDLE.
- stall = 1 in IDLE (when access_valid), REQ, and RESP.
- funct3 decoding:
  - 0 = byte (LB/SB), 1 = half (LH/SH), 2 = word (LW/SW), 4 = LBU, 5 = LHU.
  - 3, 6, and 7 are treated as word access.
  - For stores, bit 2 is ignored.
- Store lanes:
  - Byte: bus_be = 1 << addr[1:0]; bus_wdata = {4{data[7:0]}}.
  - Half: bus_be = addr[1] ? 4'b1100 : 4'b0011; bus_wdata = {2{data[15:0]}}.
  - Word: bus_be = 4'b1111.
- Loads:
  - bus_be follows the same rules as stores; bus_wdata = 0.
  - The result is bus_rdata shifted right by 8*addr[1:0], then sign-extended (LB/LH) or zero-extended (LBU/LHU) from bit 7 or bit 15.
- load_data_mw holds its value until the next load captures; stores do not change it.
- Reset values:
  - FSM = IDLE.
  - bus_req = bus_we = 0.
  - bus_addr = 0, bus_be = 0, bus_wdata = 0.
  - load_data_mw = 0, misalign = 0.
  - stall follows access_valid combinationally, even during reset.

## Timing
- A store with bus_gnt in the first REQ cycle stalls for 2 cycles (IDLE, REQ); the advance happens on the DONE edge.
- A load with bus_gnt in the first REQ cycle and bus_rvalid one cycle later stalls for 3 cycles.
- load_data_mw is valid from the DONE cycle onward, so it is valid throughout the instruction's MW cycle.
- Each cycle without bus_gnt or bus_rvalid adds one stall cycle; there is no timeout.
- Reset asserted mid-transaction drops bus_req asynchronously and abandons the access. A late bus_rvalid after reset is ignored because the FSM is in IDLE.
- Back-to-back accesses: after DONE, the next access starts in the IDLE cycle. Minimum spacing between bus_req assertions is 3 cycles.

## Configuration
- DMEM_MISALIGN_CHECK_EN, when defined:
  - A half access with addr[0] = 1, or a word access with addr[1:0] != 0, issues no bus transaction.
  - Path is IDLE→DONE, with misalign = 1 in DONE.
  - load_data_mw is unchanged.
- When undefined:
  - misalign is tied to 0.
  - A misaligned half uses the lane chosen by addr[1], ignoring addr[0].
  - A misaligned word uses bus_be = 4'b1111 on the aligned word, and the load result is truncated by the shift (upper bytes zero before extension).

## Structure
- Shared package dmem_pkg holds:
  - funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the FSM state typedef (IDLE, REQ, RESP, DONE);
  - byte-enable constants.
- Sub-module load_align: combinational, taking bus_rdata, addr[1:0], and funct3 and producing the extended value. It is reused by the bench's reference model.

## Test plan
- SB to 0x1003 with data 0xA5, grant in the first REQ cycle → bus_be = 4'b1000, bus_wdata = 0xA5A5A5A5, bus_addr = 0x1000, stall high for 2 cycles.
- LB from 0x2001, grant immediately, rdata = 0x0000_8000 one cycle later → load_data_mw = 0xFFFF_FF80, stall for 3 cycles. LBU from the same address → 0x0000_0080.
- LH from 0x2002, rdata = 0x1234_5678 → load_data_mw = 0x0000_1234; bus_be = 4'b1100.
- SW with bus_gnt withheld for 4 cycles → bus_req and all bus fields stable for 5 cycles, stall for 6 cycles total.
- Reset asserted in RESP → bus_req low immediately, FSM in IDLE; a late bus_rvalid leaves load_data_mw = 0.
- With DMEM_MISALIGN_CHECK_EN, LW from 0x3002 → no bus_req, misalign pulses for 1 cycle, stall for 1 cycle, load_data_mw unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory access unit.
//   - funct3 access-size/signedness codes (F3_*)
//   - FSM state type for dmem_access_unit
//   - byte-enable patterns and a size decoder used for both loads and stores
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_ALL     = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } dmem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } access_size_t;

    // Only funct3[1:0] selects the size: bit 2 is signedness for loads and
    // ignored for stores, and codes 3/6/7 fall through to word.
    function automatic access_size_t decode_size(input logic [1:0] f3_lo);
        case (f3_lo)
            2'd0:    return SZ_BYTE;
            2'd1:    return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    // A misaligned half keeps the lane picked by addr[1]; a misaligned word
    // still enables the whole aligned word.
    function automatic logic [3:0] byte_enables(input access_size_t size,
                                                input logic [1:0] offset);
        case (size)
            SZ_BYTE: return BE_BYTE0 << offset;
            SZ_HALF: return offset[1] ? BE_HI_HALF : BE_LO_HALF;
            default: return BE_ALL;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_unit_load_align.sv
// load_align: combinational load-data aligner.
//   rdata       in  DATAW  raw word from the data bus
//   byte_offset in  2      low address bits of the access
//   funct3      in  3      load size and signedness
//   result      out DATAW  rdata shifted right by 8*byte_offset, then
//                          sign-extended (LB/LH) or zero-extended (LBU/LHU);
//                          word-class codes pass the shifted value through.
module load_align
    import dmem_pkg::*;
#(
    parameter int DATAW = 32
) (
    input  logic [DATAW-1:0] rdata,
    input  logic [1:0]       byte_offset,
    input  logic [2:0]       funct3,
    output logic [DATAW-1:0] result
);

    logic [DATAW-1:0] shifted;

    always_comb begin
        shifted = rdata >> {byte_offset, 3'b000};
        case (funct3)
            F3_B:    result = {{(DATAW-8){shifted[7]}},   shifted[7:0]};
            F3_H:    result = {{(DATAW-16){shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {{(DATAW-8){1'b0}},         shifted[7:0]};
            F3_HU:   result = {{(DATAW-16){1'b0}},        shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: Memory-stage data access unit for the RV32I pipeline.
// Turns the XM-stage load/store into a req/gnt (+rvalid for loads) bus
// transaction, stalls the pipeline until it completes and returns the
// aligned, extended load value to MW.
//
// Ports:
//   clock, reset          clock (rising edge), async active-high reset
//   access_valid          XM holds a load/store (stable while stall)
//   mem_rw                1 = store, 0 = load
//   funct3_xm             access size / signedness
//   addr_xm               byte address
//   store_data_xm         rs2 store value
//   bus_req/we/addr/be/wdata  registered bus request fields
//   bus_gnt, bus_rvalid, bus_rdata  bus responses
//   stall                 freeze PC/DX/XM (combinational)
//   load_data_mw          registered load result for writeback
//   misalign              registered 1-cycle misalignment flag
//
// Optional feature: define DMEM_MISALIGN_CHECK_EN to reject misaligned
// half/word accesses (no bus transaction, misalign pulses in DONE).
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int DATAW     = 32,
    parameter int BUS_ADDRW = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 access_valid,
    input  logic                 mem_rw,
    input  logic [2:0]           funct3_xm,
    input  logic [BUS_ADDRW-1:0] addr_xm,
    input  logic [DATAW-1:0]     store_data_xm,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [BUS_ADDRW-1:0] bus_addr,
    output logic [3:0]           bus_be,
    output logic [DATAW-1:0]     bus_wdata,
    input  logic                 bus_gnt,
    input  logic                 bus_rvalid,
    input  logic [DATAW-1:0]     bus_rdata,
    output logic                 stall,
    output logic [DATAW-1:0]     load_data_mw,
    output logic                 misalign
);

    dmem_state_t      state_q, state_d;
    access_size_t     size_xm;
    logic [3:0]       be_xm;
    logic [DATAW-1:0] wdata_xm;
    logic             misaligned_xm;
    logic [1:0]       offset_q;
    logic [2:0]       funct3_q;
    logic [DATAW-1:0] load_aligned;

    assign size_xm = decode_size(funct3_xm[1:0]);
    assign be_xm   = byte_enables(size_xm, addr_xm[1:0]);

    always_comb begin
        wdata_xm = '0;
        if (mem_rw) begin
            case (size_xm)
                SZ_BYTE: wdata_xm = {4{store_data_xm[7:0]}};
                SZ_HALF: wdata_xm = {2{store_data_xm[15:0]}};
                default: wdata_xm = store_data_xm;
            endcase
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misaligned_xm = ((size_xm == SZ_HALF) && addr_xm[0]) ||
                           ((size_xm == SZ_WORD) && (addr_xm[1:0] != 2'b00));
`else
    assign misaligned_xm = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                stall = access_valid;
                if (access_valid) state_d = misaligned_xm ? DONE : REQ;
            end
            REQ: begin
                stall = 1'b1;
                // bus_we is the latched direction of the access in flight
                if (bus_gnt) state_d = bus_we ? DONE : RESP;
            end
            RESP: begin
                stall = 1'b1;
                if (bus_rvalid) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // offset/funct3 are kept so RESP can align data after XM inputs move on
    load_align #(.DATAW(DATAW)) u_load_align (
        .rdata       (bus_rdata),
        .byte_offset (offset_q),
        .funct3      (funct3_q),
        .result      (load_aligned)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_be       <= BE_NONE;
            bus_wdata    <= '0;
            offset_q     <= '0;
            funct3_q     <= '0;
            load_data_mw <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access_valid && !misaligned_xm) begin
                        bus_req   <= 1'b1;
                        bus_we    <= mem_rw;
                        bus_addr  <= {addr_xm[BUS_ADDRW-1:2], 2'b00};
                        bus_be    <= be_xm;
                        bus_wdata <= wdata_xm;
                        offset_q  <= addr_xm[1:0];
                        funct3_q  <= funct3_xm;
                    end
                end
                REQ: begin
                    if (bus_gnt) bus_req <= 1'b0;
                end
                RESP: begin
                    if (bus_rvalid) load_data_mw <= load_aligned;
                end
                default: ;
            endcase
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) misalign <= 1'b0;
        else       misalign <= (state_q == IDLE) && access_valid && misaligned_xm;
    end
`else
    assign misalign = 1'b0;
`endif

endmodule
